inst_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/inst_fetch_unit.sv | 70 +++++++
 tb/tb_inst_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a flush that empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; the empty flag gates everything read from it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives the ROM, queues {pc, inst} pairs for decode, handles redirects.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst
);

    logic [31:0]  fetch_pc;
    logic         deq;
    logic         enq;
    logic         q_empty;
    logic         q_full;
    fetch_entry_t q_head;
    fetch_entry_t q_in;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign rom_addr = fetch_pc[ADDR_W-1:0];

    // if_valid is pure queue state, so deq never loops back into the outputs.
    assign deq = if_valid & if_ready;
    assign enq = ~redirect_valid & (~q_full | deq);

    assign q_in.pc   = fetch_pc;
    assign q_in.inst = rom_inst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (enq) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // A deq coinciding with a redirect still completes: decode takes the head before the flush lands.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (q_in),
        .pop       (deq),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign if_valid = ~q_empty;
    assign if_pc    = q_empty ? 32'h0000_0000 : q_head.pc;
    assign if_inst  = q_empty ? NOP_INST : q_head.inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table plus throughput and redirect-bubble sequences.
module tb_inst_fetch_unit;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2;
    localparam int NVEC   = 28;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_pc;
    logic [31:0]       if_inst;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // ROM model: word = NOP + byte address.
    assign rom_inst = 32'h0000_0013 + {{(32-ADDR_W){1'b0}}, rom_addr};

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rst_n, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic [31:0] e_addr);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int exp_pc;
        int bubble;
        logic seen;

        reset_n        = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //              rst rdy rv  rpc            valid pc             inst           rom_addr
        tbl[0]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          32'h13,        32'h000);
        tbl[1]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h13,        32'h000);
        tbl[2]  = mk(1, 1, 0, 32'h0,          1, 32'h0,          32'h13,        32'h004);
        tbl[3]  = mk(1, 1, 0, 32'h0,          1, 32'h4,          32'h17,        32'h008);
        tbl[4]  = mk(1, 1, 0, 32'h0,          1, 32'h8,          32'h1B,        32'h00C);
        tbl[5]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          32'h13,        32'h000);
        tbl[6]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h13,        32'h000);
        tbl[7]  = mk(1, 0, 0, 32'h0,          1, 32'h0,          32'h13,        32'h004);
        tbl[8]  = mk(1, 0, 0, 32'h0,          1, 32'h0,          32'h13,        32'h008);
        tbl[9]  = mk(1, 0, 0, 32'h0,          1, 32'h0,          32'h13,        32'h008);
        tbl[10] = mk(1, 0, 0, 32'h0,          1, 32'h0,          32'h13,        32'h008);
        tbl[11] = mk(1, 1, 0, 32'h0,          1, 32'h0,          32'h13,        32'h008);
        tbl[12] = mk(1, 1, 0, 32'h0,          1, 32'h4,          32'h17,        32'h00C);
        tbl[13] = mk(1, 1, 1, 32'h0000_0043,  1, 32'h8,          32'h1B,        32'h010);
        tbl[14] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h13,        32'h040);
        tbl[15] = mk(1, 0, 0, 32'h0,          1, 32'h40,         32'h53,        32'h044);
        tbl[16] = mk(1, 0, 1, 32'h0000_0100,  1, 32'h40,         32'h53,        32'h048);
        tbl[17] = mk(1, 0, 1, 32'h0000_0202,  0, 32'h0,          32'h13,        32'h100);
        tbl[18] = mk(1, 0, 0, 32'h0,          0, 32'h0,          32'h13,        32'h200);
        tbl[19] = mk(1, 0, 1, 32'hFFFF_FFF8,  1, 32'h200,        32'h213,       32'h204);
        tbl[20] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h13,        32'hFF8);
        tbl[21] = mk(1, 1, 0, 32'h0,          1, 32'hFFFF_FFF8,  32'h100B,      32'hFFC);
        tbl[22] = mk(1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'h100F,      32'h000);
        tbl[23] = mk(1, 0, 0, 32'h0,          1, 32'h0,          32'h13,        32'h004);
        tbl[24] = mk(1, 0, 0, 32'h0,          1, 32'h0,          32'h13,        32'h008);
        tbl[25] = mk(0, 0, 0, 32'h0,          0, 32'h0,          32'h13,        32'h000);
        tbl[26] = mk(1, 1, 0, 32'h0,          0, 32'h0,          32'h13,        32'h000);
        tbl[27] = mk(1, 1, 0, 32'h0,          1, 32'h0,          32'h13,        32'h004);

        // Each vector: drive on the falling edge, check current state, then the rising edge consumes inputs.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            reset_n        = tbl[i].rst_n;
            if_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("v%0d.valid", i), {31'b0, if_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("v%0d.pc", i), if_pc, tbl[i].e_pc);
            chk($sformatf("v%0d.inst", i), if_inst, tbl[i].e_inst);
            chk($sformatf("v%0d.rom_addr", i), {20'b0, rom_addr}, tbl[i].e_addr);
        end

        // Throughput under ready pattern 1,1,0: every delivered pc is the next sequential one.
        @(negedge clk);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        exp_pc  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if_ready = (cyc % 3 != 2);
            #1;
            if (if_valid && if_ready) begin
                chk($sformatf("stream%0d.pc", cyc), if_pc, 32'(exp_pc));
                chk($sformatf("stream%0d.inst", cyc), if_inst, 32'h13 + 32'(exp_pc));
                exp_pc += 4;
            end
        end
        chk("stream.delivered_bytes", 32'(exp_pc), 32'd76);

        // Redirect bubble with if_ready high: target appears exactly two cycles later.
        @(negedge clk);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0123;
        bubble = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            if (if_valid) begin
                seen   = 1'b1;
                bubble = k;
            end
        end
        chk("redir.seen", {31'b0, seen}, 32'd1);
        chk("redir.latency", 32'(bubble), 32'd2);
        chk("redir.pc", if_pc, 32'h0000_0120);
        chk("redir.inst", if_inst, 32'h0000_0133);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
